// File: rtl/conv_relu_pool_1d_pkg.sv
// Shared helpers for the conv/ReLU/pool stage: accumulator sizing, pool mode codes, log2.
package crp_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One extra bit beyond the TAPS-way product sum leaves room for the bias.
  function automatic int acc_width(input int wd, input int wk, input int taps);
    return wd + wk + log2c(taps) + 1;
  endfunction

endpackage

// File: rtl/conv_relu_pool_1d_pool.sv
// Pool unit: groups POOL_SIZE ReLU results into a max or a truncating average.
// Define CRP_SAT_EN to clamp the pooled value into [0, 2^(OUT_W-1)-1].
module crp_pool
  import crp_pkg::*;
#(
  parameter int ACC_W     = 28,
  parameter int POOL_SIZE = 4,
  parameter int OUT_W     = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic signed [ACC_W-1:0] i_data,
  output logic [OUT_W-1:0]        o_data,
  output logic                    o_flag
);
  localparam int LOG2P = log2c(POOL_SIZE);
  localparam int SUM_W = ACC_W + LOG2P;

  logic [LOG2P-1:0]        r_cnt;
  logic signed [SUM_W-1:0] r_acc;

  logic [LOG2P-1:0]        w_cnt;
  logic signed [SUM_W-1:0] w_in;
  logic signed [SUM_W-1:0] w_next;
  logic signed [ACC_W-1:0] w_pooled;
  logic [OUT_W-1:0]        w_out;

`ifdef CRP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
`endif

  // A first result of a new frame restarts the group, dropping any partial one.
  always_comb begin
    w_cnt = i_start ? '0 : r_cnt;
    w_in  = SUM_W'(i_data);
    if (w_cnt == '0) begin
      w_next = w_in;
    end else if (i_mode == POOL_AVG) begin
      w_next = r_acc + w_in;
    end else begin
      w_next = (w_in > r_acc) ? w_in : r_acc;
    end
    w_pooled = (i_mode == POOL_AVG) ? w_next[SUM_W-1:LOG2P] : w_next[ACC_W-1:0];
`ifdef CRP_SAT_EN
    if (w_pooled[ACC_W-1]) begin
      w_out = '0;
    end else if (w_pooled > SAT_MAX) begin
      w_out = SAT_MAX[OUT_W-1:0];
    end else begin
      w_out = w_pooled[OUT_W-1:0];
    end
`else
    w_out = w_pooled;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      o_data <= '0;
      o_flag <= 1'b0;
    end else begin
      o_flag <= 1'b0;
      if (i_valid) begin
        if (w_cnt == LOG2P'(POOL_SIZE - 1)) begin
          o_data <= w_out;
          o_flag <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_acc <= w_next;
          r_cnt <= w_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_relu_pool_1d.sv
// Streaming TAPS-tap conv + bias + ReLU + POOL_SIZE pool, restartable per frame via sof_i.
// Define CRP_SAT_EN for a WIDTH_DATA-wide clamped output instead of the full ACC_W result.
module conv_relu_pool_1d
  import crp_pkg::*;
#(
  parameter int WIDTH_DATA   = 16,
  parameter int WIDTH_KERNEL = 8,
  parameter int TAPS         = 5,
  parameter int POOL_SIZE    = 4,
  localparam int ACC_W       = acc_width(WIDTH_DATA, WIDTH_KERNEL, TAPS),
`ifdef CRP_SAT_EN
  localparam int OUT_W       = WIDTH_DATA
`else
  localparam int OUT_W       = ACC_W
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  input  logic                         sof_i,
  input  logic [WIDTH_DATA-1:0]        data_i,
  input  logic [TAPS*WIDTH_KERNEL-1:0] kernel_i,
  input  logic [WIDTH_KERNEL-1:0]      bias_i,
  input  logic                         pool_mode_i,
  output logic [OUT_W-1:0]             data_o,
  output logic                         flag_o
);
  localparam int PROD_W = WIDTH_DATA + WIDTH_KERNEL;
  localparam int FILL_W = log2c(TAPS + 1);

  if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
    $error("conv_relu_pool_1d: TAPS must be 2..16");
  end
  if (POOL_SIZE < 2 || POOL_SIZE > 16 || (POOL_SIZE & (POOL_SIZE - 1)) != 0) begin : g_bad_pool
    $error("conv_relu_pool_1d: POOL_SIZE must be a power of two in 2..16");
  end

  logic signed [WIDTH_DATA-1:0]   r_win [TAPS];
  logic [FILL_W-1:0]              r_fill;
  logic                           r_needSof;
  logic                           r_firstOp;
  logic [TAPS*WIDTH_KERNEL-1:0]   r_kernel;
  logic signed [WIDTH_KERNEL-1:0] r_bias;
  logic                           r_poolMode;

  logic                           r_v0, r_tag0, r_mode0;
  logic signed [WIDTH_KERNEL-1:0] r_bias0;
  logic                           r_v1, r_tag1, r_mode1;
  logic signed [WIDTH_KERNEL-1:0] r_bias1;
  logic signed [PROD_W-1:0]       r_prod [TAPS];
  logic                           r_v2, r_tag2, r_mode2;
  logic signed [ACC_W-1:0]        r_sum;
  logic                           r_v3, r_tag3, r_mode3;
  logic signed [ACC_W-1:0]        r_relu;

  logic                           w_sof;
  logic [FILL_W-1:0]              w_fillNext;
  logic                           w_issue;
  logic signed [ACC_W-1:0]        w_sum;

  // The very first accepted sample after reset opens a frame even without sof_i.
  always_comb begin
    w_sof = valid_i && (sof_i || r_needSof);
    if (w_sof) begin
      w_fillNext = FILL_W'(1);
    end else if (r_fill == FILL_W'(TAPS)) begin
      w_fillNext = r_fill;
    end else begin
      w_fillNext = r_fill + 1'b1;
    end
    w_issue = valid_i && (w_fillNext == FILL_W'(TAPS));
  end

  always_comb begin
    w_sum = ACC_W'(r_bias1);
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
  end

  // Bias, mode and frame tag travel with each op so a new frame cannot corrupt old ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_win[i]  <= '0;
        r_prod[i] <= '0;
      end
      r_fill     <= '0;
      r_needSof  <= 1'b1;
      r_firstOp  <= 1'b0;
      r_kernel   <= '0;
      r_bias     <= '0;
      r_poolMode <= POOL_MAX;
      {r_v0, r_tag0, r_mode0, r_bias0} <= '0;
      {r_v1, r_tag1, r_mode1, r_bias1} <= '0;
      {r_v2, r_tag2, r_mode2, r_sum}   <= '0;
      {r_v3, r_tag3, r_mode3, r_relu}  <= '0;
    end else begin
      if (valid_i) begin
        r_win[0] <= data_i;
        for (int i = 1; i < TAPS; i++) r_win[i] <= r_win[i-1];
        r_fill    <= w_fillNext;
        r_needSof <= 1'b0;
      end
      if (w_sof) begin
        r_kernel   <= kernel_i;
        r_bias     <= bias_i;
        r_poolMode <= pool_mode_i;
        r_firstOp  <= 1'b1;
      end else if (w_issue) begin
        r_firstOp <= 1'b0;
      end

      r_v0 <= w_issue;
      if (w_issue) begin
        r_tag0  <= r_firstOp;
        r_mode0 <= r_poolMode;
        r_bias0 <= r_bias;
      end

      r_v1 <= r_v0;
      if (r_v0) begin
        r_tag1  <= r_tag0;
        r_mode1 <= r_mode0;
        r_bias1 <= r_bias0;
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= PROD_W'($signed(r_kernel[k*WIDTH_KERNEL +: WIDTH_KERNEL]))
                     * PROD_W'(r_win[TAPS-1-k]);
        end
      end

      r_v2 <= r_v1;
      if (r_v1) begin
        r_tag2  <= r_tag1;
        r_mode2 <= r_mode1;
        r_sum   <= w_sum;
      end

      r_v3 <= r_v2;
      if (r_v2) begin
        r_tag3  <= r_tag2;
        r_mode3 <= r_mode2;
        r_relu  <= r_sum[ACC_W-1] ? '0 : r_sum;
      end
    end
  end

  crp_pool #(
    .ACC_W    (ACC_W),
    .POOL_SIZE(POOL_SIZE),
    .OUT_W    (OUT_W)
  ) u_pool (
    .clk    (clk),
    .rst    (rst),
    .i_valid(r_v3),
    .i_start(r_tag3),
    .i_mode (r_mode3),
    .i_data (r_relu),
    .o_data (data_o),
    .o_flag (flag_o)
  );

endmodule
